// File: rtl/ptp_ts_harvester_if.sv
// ptp_ts_harvester_if: register-bus, interrupt and timestamp-record stream signals of the harvester
interface ptp_ts_harvester_if;
  logic int_rx_ptp_i;
  logic int_tx_ptp_i;
  logic [31:0] bus2ip_addr_o;
  logic [31:0] bus2ip_data_o;
  logic bus2ip_rd_ce_o;
  logic bus2ip_wr_ce_o;
  logic [31:0] ip2bus_data_i;
  logic ts_valid_o;
  logic ts_ready_i;
  logic ts_dir_o;
  logic [127:0] ts_data_o;
  modport master (
    input int_rx_ptp_i, int_tx_ptp_i, ip2bus_data_i, ts_ready_i,
    output bus2ip_addr_o, bus2ip_data_o, bus2ip_rd_ce_o, bus2ip_wr_ce_o, ts_valid_o, ts_dir_o, ts_data_o
  );
  modport slave (
    output int_rx_ptp_i, int_tx_ptp_i, ip2bus_data_i, ts_ready_i,
    input bus2ip_addr_o, bus2ip_data_o, bus2ip_rd_ce_o, bus2ip_wr_ce_o, ts_valid_o, ts_dir_o, ts_data_o
  );
endinterface

// File: rtl/ptp_ts_harvester.sv
// ptp_ts_harvester: reads PTP rx/tx timestamp records into a valid/ready FIFO; define PTP_HARVEST_CLR_EN to also issue the interrupt-clear write
module ptp_ts_harvester #(
  parameter logic [31:0] RX_BASE = 32'h0000_0100,
  parameter logic [31:0] TX_BASE = 32'h0000_0140,
  parameter logic [31:0] INT_CLR_ADDR = 32'h0000_0180,
  parameter logic [31:0] RX_CLR_VAL = 32'h0000_0001,
  parameter logic [31:0] TX_CLR_VAL = 32'h0000_0002,
  parameter int RD_LAT = 1,
  parameter int DEPTH = 4,
  parameter int GUARD = 2
) (
  input logic bus2ip_clk,
  input logic bus2ip_rst,
  ptp_ts_harvester_if.master bus
);
`ifdef PTP_HARVEST_CLR_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_CLR = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;
  logic [2:0] state;
  logic [2:0] state_n;
  logic [7:0] cnt;
  logic [1:0] k;
  logic dir;
  logic [127:0] rec;
  logic [128:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [128:0] head_n;
  logic [128:0] head_q;
  logic valid_q;
  logic start;
  logic lat_done;
  logic guard_done;
  logic push;
  logic pop;
  logic rd_ce;
  logic wr_ce;
  assign start = (bus.int_rx_ptp_i | bus.int_tx_ptp_i) && count != CW'(DEPTH);
  assign lat_done = cnt == 8'(RD_LAT - 1);
  assign guard_done = cnt == 8'(GUARD - 1);
  assign push = state == S_CLR;
  assign pop = valid_q & bus.ts_ready_i;
  assign rd_ptr_n = rd_ptr + AW'(pop);
  assign count_n = count + CW'(push) - CW'(pop);
  assign head_n = count_n == '0 ? '0 : count == CW'(pop) ? {dir, rec} : mem[rd_ptr_n];
  assign state_n = state == S_IDLE ? (start ? S_RD_ISSUE : S_IDLE)
                 : state == S_RD_ISSUE ? S_RD_WAIT
                 : state == S_RD_WAIT ? (!lat_done ? S_RD_WAIT : k == 2'd3 ? S_CLR : S_RD_ISSUE)
                 : state == S_CLR ? (GUARD == 0 ? S_IDLE : S_GUARD)
                 : guard_done ? S_IDLE : S_GUARD;
  assign rd_ce = state == S_RD_ISSUE;
  assign wr_ce = CLR_EN && state == S_CLR;
  assign bus.bus2ip_rd_ce_o = rd_ce;
  assign bus.bus2ip_wr_ce_o = wr_ce;
  assign bus.bus2ip_addr_o = rd_ce ? (dir ? TX_BASE : RX_BASE) + {28'd0, k, 2'b00} : wr_ce ? INT_CLR_ADDR : '0;
  assign bus.bus2ip_data_o = wr_ce ? (dir ? TX_CLR_VAL : RX_CLR_VAL) : '0;
  assign bus.ts_valid_o = valid_q;
  assign bus.ts_dir_o = head_q[128];
  assign bus.ts_data_o = head_q[127:0];
  always_ff @(posedge bus2ip_clk) begin
    if (push) mem[wr_ptr] <= {dir, rec};
    if (bus2ip_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      k <= '0;
      dir <= 1'b0;
      rec <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid_q <= 1'b0;
      head_q <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n == state ? cnt + 8'd1 : '0;
      k <= state == S_IDLE ? 2'd0 : (state == S_RD_WAIT && lat_done) ? k + 2'd1 : k;
      if (state == S_IDLE && start) dir <= !bus.int_rx_ptp_i;
      if (state == S_RD_WAIT && lat_done) rec[{k, 5'd0} +: 32] <= bus.ip2bus_data_i;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_n;
      count <= count_n;
      valid_q <= count_n != '0;
      head_q <= head_n;
    end
  end
endmodule

// File: doc/ptp_ts_harvester.md
# ptp_ts_harvester

Bus-initiator companion to the PTPv2 core's 32-bit on-chip register slave. It watches the core's receive and transmit timestamp interrupts and issues the register reads that fetch each four-word timestamp record. When the PTP_HARVEST_CLR_EN macro is defined, it also issues the interrupt-clear write. Captured records go into a small record FIFO and are presented to a host or DMA through a valid/ready stream, so software never polls the core's registers directly.

## Interface
Parameters:
- RX_BASE, 32'h0000_0100: byte address of rx timestamp word 0.
- TX_BASE, 32'h0000_0140: byte address of tx timestamp word 0.
- INT_CLR_ADDR, 32'h0000_0180: interrupt-clear register address.
- RX_CLR_VAL, 32'h0000_0001: value written to clear the rx interrupt.
- TX_CLR_VAL, 32'h0000_0002: value written to clear the tx interrupt.
- RD_LAT, 1: cycles from the rd_ce pulse to valid ip2bus_data; range 1..4.
- DEPTH, 4: record FIFO depth; power of 2, minimum 2.
- GUARD, 2: cycles after a clear before the interrupts are re-sampled.

Ports:
- bus2ip_clk  in  1  sole clock.
- bus2ip_rst  in  1  synchronous, active-high reset.
- int_rx_ptp_i  in  1  level rx timestamp interrupt, synchronous to bus2ip_clk.
- int_tx_ptp_i  in  1  level tx timestamp interrupt, synchronous to bus2ip_clk.
- bus2ip_addr_o  out  32  register address.
- bus2ip_data_o  out  32  write data.
- bus2ip_rd_ce_o  out  1  single-cycle read strobe.
- bus2ip_wr_ce_o  out  1  single-cycle write strobe.
- ip2bus_data_i  in  32  read data returned by the core.
- ts_valid_o  out  1  FIFO non-empty.
- ts_ready_i  in  1  consumer accepts the head record.
- ts_dir_o  out  1  head record source: 0 = rx, 1 = tx.
- ts_data_o  out  128  head record; [31:0] = word 0 (lowest address), up to [127:96] = word 3.

## Operation
- FSM states are IDLE, RD_ISSUE, RD_WAIT, CLR, GUARD.
- IDLE:
  - Starts a harvest if at least one interrupt is high and the FIFO count is below DEPTH.
  - Rx has priority when both interrupts are high; tx is taken on the next IDLE pass.
  - Latches the direction and the base address, clears the word index k, and goes to RD_ISSUE.
  - With the FIFO full, stays in IDLE; the interrupt stays pending (level), so nothing is lost.
- RD_ISSUE drives bus2ip_addr_o = base + 4*k with rd_ce high for one cycle, then goes to RD_WAIT.
- RD_WAIT:
  - Counts RD_LAT cycles, then captures ip2bus_data_i into word k on the last of them.
  - If k < 3: k increments and the FSM returns to RD_ISSUE.
  - If k = 3: the FSM goes to CLR.
- CLR:
  - Drives INT_CLR_ADDR and RX_CLR_VAL or TX_CLR_VAL with wr_ce high for one cycle.
  - Pushes {dir, 4 words} into the FIFO in the same cycle, then goes to GUARD.
- GUARD waits GUARD cycles so the cleared interrupt can fall, then returns to IDLE.
- FIFO:
  - Pop happens when ts_valid_o and ts_ready_i are both high; the FIFO is first-word-fall-through and in order.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - A push never hits a full FIFO, because a harvest starts only with space available and only one record is ever in flight.
- When idle, bus2ip_addr_o and bus2ip_data_o are 0, and rd_ce and wr_ce are low.

## Timing
- Reset values: every output is 0; the FSM is in IDLE and the FIFO is empty.
- Reset mid-harvest aborts immediately and flushes the FIFO. No clear write is issued, so a still-pending interrupt is re-harvested after reset.
- With an interrupt sampled high at edge 0 and RD_LAT = 1:
  - rd_ce is high in cycles 1, 3, 5 and 7.
  - Captures occur at the end of cycles 2, 4, 6 and 8.
  - wr_ce and the FIFO push occur in cycle 9.
  - ts_valid_o rises in cycle 10, GUARD covers cycles 10–11, and IDLE resumes in cycle 12.
- General harvest length: 4*(RD_LAT+1) + 1 + GUARD cycles, IDLE cycle excluded.
- ts_valid_o and ts_data_o are registered; ts_valid_o drops the cycle after the last pop.

## Configuration
- PTP_HARVEST_CLR_EN defined:
  - The CLR state issues the clear write described above.
- PTP_HARVEST_CLR_EN undefined:
  - The core clears on the read of word 3.
  - The CLR state only pushes the record, with wr_ce held at 0 permanently.
  - Timing is unchanged.

## Test plan
- Single rx event: rx words 0x11, 0x22, 0x33, 0x44 at RX_BASE..RX_BASE+12, int_rx high -> reads at 0x100, 0x104, 0x108, 0x10C. Then a write of 0x1 to 0x180. Then ts_valid = 1, ts_dir = 0, ts_data = 0x00000044_00000033_00000022_00000011 in cycle 10.
- Simultaneous rx and tx: both interrupts high in the same cycle -> the rx record is harvested first, the tx harvest starts in cycle 12, and the FIFO order is rx then tx.
- Backpressure: ts_ready = 0, five tx events -> four records stored, the fifth interrupt stays pending with no bus activity. One pop -> the fifth is harvested with its data intact.
- RD_LAT = 3: single tx event -> rd_ce pulses 4 cycles apart, each capture taken exactly 3 cycles after its rd_ce, and the clear write of 0x2 in cycle 17.
- Reset in cycle 5 of a harvest -> all outputs 0 in the next cycle, the FIFO is empty, and no wr_ce occurs. The interrupt is still high, so the harvest restarts from word 0 after reset deasserts.
- Build without PTP_HARVEST_CLR_EN: single rx event -> wr_ce never asserts and the record is still pushed in cycle 9.
